// File: rtl/alu_share_arb.sv
// Round-robin arbiter time-sharing one W-bit ALU (add/sub/and/xor) between two requesters; owns cc {ZF,SF,OF}.
// Latency: result, flags and cc update are registered and visible one cycle after accept.
// Backpressure: no grant while the result register is full and not being drained; reload in the drain cycle.
module alu_share_arb #(
  parameter int         W        = 64,
  parameter logic [2:0] CC_RESET = 3'b100
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [1:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_setcc,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [1:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_setcc,
  output logic         rsp_valid,
  output logic         rsp_id,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic [2:0]   rsp_flags,
  output logic [2:0]   cc
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef struct packed {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         setcc;
  } alu_req_t;

  logic         last_grant;
  logic         slot_free;
  logic         gnt0;
  logic         gnt1;
  logic         accept;
  logic         winner;
  alu_req_t     sel;
  logic [W-1:0] alu_r;
  logic         alu_of;
  logic [2:0]   alu_flags;

  // Round-robin grant: requester that did not win last time takes a tie; nothing while the slot is busy or in reset.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    slot_free = !rsp_valid || rsp_ready;
    if (rst_n && slot_free) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_grant;
        gnt1 = !last_grant;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign accept     = gnt0 || gnt1;
  assign winner     = gnt1;

  // Steer the winning requester's operands into the shared ALU.
  always_comb begin
    sel = winner ? alu_req_t'{req1_op, req1_a, req1_b, req1_setcc}
                 : alu_req_t'{req0_op, req0_a, req0_b, req0_setcc};
  end

  // Shared ALU; subtract is b - a, and overflow is a signed-operand sign mismatch.
  always_comb begin
    alu_r  = '0;
    alu_of = 1'b0;
    case (sel.op)
      OP_ADD: begin
        alu_r  = sel.a + sel.b;
        alu_of = (sel.a[W-1] == sel.b[W-1]) && (alu_r[W-1] != sel.a[W-1]);
      end
      OP_SUB: begin
        alu_r  = sel.b - sel.a;
        alu_of = (sel.a[W-1] != sel.b[W-1]) && (alu_r[W-1] != sel.b[W-1]);
      end
      OP_AND: alu_r = sel.a & sel.b;
      OP_XOR: alu_r = sel.a ^ sel.b;
      default: alu_r = '0;
    endcase
    alu_flags = {(alu_r == '0), alu_r[W-1], alu_of};
  end

  // Result register, cc and round-robin pointer; an accept in a drain cycle overwrites in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_flags  <= 3'b000;
      cc         <= CC_RESET;
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= winner;
      rsp_valid  <= 1'b1;
      rsp_id     <= winner;
      rsp_data   <= alu_r;
      rsp_flags  <= alu_flags;
      if (sel.setcc) begin
        cc <= alu_flags;
      end
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: reset, ALU results/flags, cc update, round-robin, backpressure.
// Latency: inputs driven 1 time unit after the rising edge; registered outputs checked after the edge.
// Backpressure: exercised by holding rsp_ready low for several cycles with both requesters pending.
module tb_alu_share_arb;

  localparam int W = 64;

  logic         clk;
  logic         rst_n;
  logic         req0_valid, req0_ready, req0_setcc;
  logic [1:0]   req0_op;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_setcc;
  logic [1:0]   req1_op;
  logic [W-1:0] req1_a, req1_b;
  logic         rsp_valid, rsp_id, rsp_ready;
  logic [W-1:0] rsp_data;
  logic [2:0]   rsp_flags;
  logic [2:0]   cc;

  int errors = 0;
  int checks = 0;

  alu_share_arb #(.W(W), .CC_RESET(3'b100)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_setcc (req0_setcc),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_setcc (req1_setcc),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_flags  (rsp_flags),
    .cc         (cc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [1:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic s);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_setcc = s;
  endtask

  task automatic set1(input logic v, input logic [1:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic s);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_setcc = s;
  endtask

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    set0(1'b0, 2'b00, '0, '0, 1'b0);
    set1(1'b0, 2'b00, '0, '0, 1'b0);
    cyc();
    cyc();
    check("rst_valid", rsp_valid, 0);
    check("rst_id",    rsp_id,    0);
    check("rst_data",  rsp_data,  0);
    check("rst_flags", rsp_flags, 0);
    check("rst_cc",    cc,        3'b100);

    // Put some state in the registers, then hit reset mid-cycle.
    rst_n = 1'b1;
    set0(1'b1, 2'b00, 64'd5, 64'd6, 1'b1);
    #1;
    check("pre_rdy0", req0_ready, 1);
    check("pre_rdy1", req1_ready, 0);
    cyc();
    req0_valid = 1'b0;
    check("pre_data", rsp_data, 64'd11);
    check("pre_cc",   cc,       3'b000);
    #2;
    rst_n = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check("arst_valid", rsp_valid,  0);
    check("arst_cc",    cc,         3'b100);
    check("arst_rdy0",  req0_ready, 0);
    check("arst_rdy1",  req1_ready, 0);
    #1;
    rst_n = 1'b1;

    // Both pending after reset: requester 0 wins first.
    set0(1'b1, 2'b11, 64'hB, 64'h4, 1'b0);
    set1(1'b1, 2'b11, 64'hFFFF_FFFF_FFFF_FFFE, 64'd13, 1'b1);
    rsp_ready = 1'b1;
    #1;
    check("a_rdy0", req0_ready, 1);
    check("a_rdy1", req1_ready, 0);
    cyc();
    check("xor0_data",  rsp_data,   64'hF);
    check("xor0_id",    rsp_id,     0);
    check("xor0_flags", rsp_flags,  3'b000);
    check("xor0_cc",    cc,         3'b100);
    check("xor0_rdy1",  req1_ready, 1);
    check("xor0_rdy0",  req0_ready, 0);
    req0_valid = 1'b0;
    cyc();
    check("xor1_data",  rsp_data,  64'hFFFF_FFFF_FFFF_FFF3);
    check("xor1_id",    rsp_id,    1);
    check("xor1_flags", rsp_flags, 3'b010);
    check("xor1_cc",    cc,        3'b010);
    req1_valid = 1'b0;
    set0(1'b1, 2'b11, 64'h9, 64'h9, 1'b0);
    cyc();
    check("xorz_data",  rsp_data,  64'h0);
    check("xorz_flags", rsp_flags, 3'b100);
    check("xorz_cc",    cc,        3'b010);

    // Signed overflow on add and on sub (b - a).
    set0(1'b1, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    cyc();
    check("addov_data",  rsp_data,  64'hFFFF_FFFF_FFFF_FFFE);
    check("addov_flags", rsp_flags, 3'b011);
    check("addov_cc",    cc,        3'b011);
    set0(1'b1, 2'b01, 64'h1, 64'h8000_0000_0000_0000, 1'b1);
    cyc();
    check("subov_data",  rsp_data,  64'h7FFF_FFFF_FFFF_FFFF);
    check("subov_flags", rsp_flags, 3'b001);
    check("subov_cc",    cc,        3'b001);

    // setcc=0 leaves cc alone even on a zero result.
    set0(1'b1, 2'b10, 64'hF0, 64'h0F, 1'b0);
    cyc();
    check("and_data",  rsp_data,  64'h0);
    check("and_flags", rsp_flags, 3'b100);
    check("and_cc",    cc,        3'b001);

    // Fresh reset, then both requesters pending every cycle.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    set0(1'b1, 2'b00, 64'd1,  64'd2,  1'b0);
    set1(1'b1, 2'b00, 64'd10, 64'd20, 1'b0);
    #1;
    for (int i = 0; i < 4; i++) begin
      logic g;
      g = i[0];
      check("rr_rdy0", req0_ready, !g);
      check("rr_rdy1", req1_ready, g);
      cyc();
      check("rr_valid", rsp_valid, 1);
      check("rr_id",    rsp_id,    g);
      check("rr_data",  rsp_data,  g ? 64'd30 : 64'd3);
    end

    // Result stalled: no grants, data held.
    rsp_ready = 1'b0;
    #1;
    check("bp_rdy0", req0_ready, 0);
    check("bp_rdy1", req1_ready, 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("bp_data",  rsp_data,   64'd30);
      check("bp_valid", rsp_valid,  1);
      check("bp_rdy",   {req0_ready, req1_ready}, 2'b00);
    end
    rsp_ready = 1'b1;
    #1;
    check("rel_rdy0", req0_ready, 1);
    check("rel_rdy1", req1_ready, 0);
    cyc();
    check("rel_data",  rsp_data,  64'd3);
    check("rel_id",    rsp_id,    0);
    check("rel_valid", rsp_valid, 1);

    // Drain with nothing pending.
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cyc();
    check("drain_valid", rsp_valid, 0);
    check("drain_data",  rsp_data,  64'd3);
    check("drain_id",    rsp_id,    0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
